// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle integer multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide share one 2*width accumulator.
// Signed operations run on magnitudes; signs are applied in a single fix-up cycle.
module mdu_seq #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mduFunc,
  input  logic [width-1:0] mduIn1,
  input  logic [width-1:0] mduIn2,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] hi,
  output logic [width-1:0] lo
);

  localparam int cntW = $clog2(width);
  localparam logic [cntW-1:0] lastCnt = cntW'(width - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mduState;

  mduState            state;
  logic [cntW-1:0]    cnt;
  logic               isDiv;
  logic               negRes;   // product / quotient must be negated
  logic               negRem;   // remainder must be negated (negative dividend)
  logic               divZero;
  logic [width-1:0]   aMag;     // multiplicand magnitude
  logic [width-1:0]   bMag;     // divisor magnitude
  logic [width-1:0]   in1Raw;   // untouched dividend, returned in HI on divide by zero
  logic [2*width-1:0] acc;      // mul: {partial sum, multiplier}; div: {remainder, dividend/quotient}

  logic               signedOp;
  logic [width-1:0]   mag1;
  logic [width-1:0]   mag2;
  logic [width:0]     mulSum;
  logic [2*width-1:0] mulNext;
  logic [width:0]     divShift;
  logic               divGe;
  logic [width-1:0]   newRem;
  logic [2*width-1:0] divNext;
  logic [2*width-1:0] prodFix;
  logic [width-1:0]   quotFix;
  logic [width-1:0]   remFix;

  // Operand magnitudes, one iteration step for each operation, and the sign fix-up values
  always_comb begin
    signedOp = ~mduFunc[0];
    mag1     = (signedOp && mduIn1[width-1]) ? -mduIn1 : mduIn1;
    mag2     = (signedOp && mduIn2[width-1]) ? -mduIn2 : mduIn2;

    // Shift-add: add multiplicand into the upper half when the current multiplier bit is set,
    // then shift the whole accumulator right; the carry becomes the new top bit.
    mulSum   = {1'b0, acc[2*width-1:width]} + (acc[0] ? {1'b0, aMag} : {(width+1){1'b0}});
    mulNext  = {mulSum, acc[width-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder, subtract if it fits.
    // The remainder is always below the divisor, so the difference fits in width bits.
    divShift = {acc[2*width-1:width], acc[width-1]};
    divGe    = divShift >= {1'b0, bMag};
    newRem   = divGe ? (divShift[width-1:0] - bMag) : divShift[width-1:0];
    divNext  = {newRem, acc[width-2:0], divGe};

    prodFix  = negRes ? -acc : acc;
    quotFix  = negRes ? -acc[width-1:0] : acc[width-1:0];
    remFix   = negRem ? -acc[2*width-1:width] : acc[2*width-1:width];
  end

  // Control FSM, iteration datapath, HI/LO registers and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      aMag    <= '0;
      bMag    <= '0;
      in1Raw  <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Latch everything the operation needs; start overrides any move-to write
            state   <= CALC;
            busy    <= 1'b1;
            cnt     <= '0;
            isDiv   <= mduFunc[1];
            negRes  <= signedOp & (mduIn1[width-1] ^ mduIn2[width-1]);
            negRem  <= signedOp & mduIn1[width-1];
            divZero <= (mduIn2 == '0);
            aMag    <= mag1;
            bMag    <= mag2;
            in1Raw  <= mduIn1;
            acc     <= {{width{1'b0}}, (mduFunc[1] ? mag1 : mag2)};
          end else begin
            if (mthi) hi <= mduIn1;
            if (mtlo) lo <= mduIn1;
          end
        end
        CALC: begin
          acc <= isDiv ? divNext : mulNext;
          cnt <= cnt + cntW'(1);
          if (cnt == lastCnt) state <= FIXUP;
        end
        FIXUP: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!isDiv) begin
            hi <= prodFix[2*width-1:width];
            lo <= prodFix[width-1:0];
          end else if (divZero) begin
            hi <= in1Raw;
            lo <= {width{1'b1}};
          end else begin
            hi <= remFix;
            lo <= quotFix;
          end
        end
        DONE: begin
          // A new start is not accepted here, but move-to writes are
          state <= IDLE;
          if (mthi) hi <= mduIn1;
          if (mtlo) lo <= mduIn1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases, randomized operations
// against an arithmetic reference model, handshake and asynchronous reset checks.
module tb_mdu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mduFunc;
  logic [31:0] mduIn1;
  logic [31:0] mduIn2;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] curHi;
  logic [31:0] curLo;

  mdu_seq #(.width(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mduFunc (mduFunc),
    .mduIn1  (mduIn1),
    .mduIn2  (mduIn2),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} computed with plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          q;
    longint          m;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned uq;
    longint unsigned um;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (f)
      2'd0: r = sa * sb;
      2'd1: r = ua * ub;
      2'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          um = ua % ub;
          r  = {um[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Runs one operation starting at a negedge; returns one cycle after the done pulse
  task automatic runOp(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eHi, input logic [31:0] eLo,
                       input bit mtDone, input logic [31:0] mtVal, input string tag);
    int k;
    int busyCnt;
    int holdViol;
    mduFunc = f;
    mduIn1  = a;
    mduIn2  = b;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    mduFunc = 2'($urandom);
    mduIn1  = $urandom;
    mduIn2  = $urandom;
    k = 1;
    busyCnt = 0;
    holdViol = 0;
    while (done !== 1'b1 && k < 100) begin
      if (busy === 1'b1) busyCnt++;
      if (hi !== curHi || lo !== curLo) holdViol++;
      @(negedge clk);
      k++;
    end
    chk($sformatf("%s.latency", tag), 64'(k), 64'd34);
    chk($sformatf("%s.busycycles", tag), 64'(busyCnt), 64'd33);
    chk($sformatf("%s.holdwhilebusy", tag), 64'(holdViol), 64'd0);
    chk($sformatf("%s.hi", tag), {32'd0, hi}, {32'd0, eHi});
    chk($sformatf("%s.lo", tag), {32'd0, lo}, {32'd0, eLo});
    $display("op %s func=%0d a=0x%h b=0x%h -> hi=0x%h lo=0x%h latency=%0d", tag, f, a, b, hi, lo, k);
    curHi = eHi;
    curLo = eLo;
    if (mtDone) begin
      mthi   = 1'b1;
      mduIn1 = mtVal;
    end
    @(negedge clk);
    mthi = 1'b0;
    chk($sformatf("%s.donepulse", tag), {63'd0, done}, 64'd0);
    chk($sformatf("%s.busyafter", tag), {63'd0, busy}, 64'd0);
    if (mtDone) begin
      chk($sformatf("%s.mthi_in_done", tag), {32'd0, hi}, {32'd0, mtVal});
      curHi = mtVal;
    end
  endtask

  initial begin
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    int          k;
    int          badCnt;

    rst = 1'b1;
    start = 1'b0;
    mduFunc = 2'd0;
    mduIn1 = '0;
    mduIn2 = '0;
    mthi = 1'b0;
    mtlo = 1'b0;
    curHi = '0;
    curLo = '0;

    // Reset state
    @(negedge clk);
    chk("reset.hi", {32'd0, hi}, 64'd0);
    chk("reset.lo", {32'd0, lo}, 64'd0);
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases
    runOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32'd0, "multu_max");
    runOp(2'd0, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32'd0, "mult_neg7x3");
    runOp(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1, 32'h1357_9BDF, "mult_minxmin");
    runOp(2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32'd0, "div_neg7by2");
    runOp(2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 32'd0, "divu_100by7");
    runOp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 32'd0, "div_overflow");
    runOp(2'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 32'd0, "divu_by0");
    runOp(2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 32'd0, "div_neg5by0");

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom_range(0, 3));
      a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      if (i % 8 == 0)      b = 32'd0;
      else if (i % 4 == 1) b = 32'(0 - int'($urandom_range(1, 9)));
      else if (i % 4 == 2) b = 32'($urandom_range(1, 20));
      else                 b = $urandom;
      r = model(f, a, b);
      runOp(f, a, b, r[63:32], r[31:0], 1'b0, 32'd0, $sformatf("rand%0d", i));
    end

    // Move-to-HI and move-to-LO together in IDLE
    mduIn1 = 32'hDEAD_BEEF;
    mthi = 1'b1;
    mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mt_both.hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
    chk("mt_both.lo", {32'd0, lo}, {32'd0, 32'hDEAD_BEEF});
    $display("op mt_both value=0x%h -> hi=0x%h lo=0x%h", 32'hDEAD_BEEF, hi, lo);
    curHi = 32'hDEAD_BEEF;
    curLo = 32'hDEAD_BEEF;

    // Restart, input changes and move-to writes mid-CALC are ignored
    mduFunc = 2'd3;
    mduIn1 = 32'd1000;
    mduIn2 = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midcalc.busy", {63'd0, busy}, 64'd1);
    start = 1'b1;
    mduFunc = 2'd0;
    mduIn1 = 32'hAAAA_5555;
    mduIn2 = 32'd5;
    mthi = 1'b1;
    mtlo = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("midcalc.hi_held", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
    chk("midcalc.lo_held", {32'd0, lo}, {32'd0, 32'hDEAD_BEEF});
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("midcalc.done_seen", {63'd0, done}, 64'd1);
    chk("midcalc.hi", {32'd0, hi}, 64'd6);
    chk("midcalc.lo", {32'd0, lo}, 64'd142);
    $display("op midcalc divu 1000/7 -> hi=0x%h lo=0x%h", hi, lo);
    curHi = 32'd6;
    curLo = 32'd142;
    // start presented during DONE must not launch an operation
    start = 1'b1;
    mduFunc = 2'd1;
    mduIn1 = 32'd2;
    mduIn2 = 32'd2;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done.busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("start_in_done.idle", {63'd0, busy}, 64'd0);
    chk("start_in_done.lo", {32'd0, lo}, 64'd142);

    // Asynchronous reset at cycle 10 of a DIV aborts it
    mduFunc = 2'd2;
    mduIn1 = 32'hFFFF_FF9C;
    mduIn2 = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort.busy_before", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort.busy", {63'd0, busy}, 64'd0);
    chk("abort.done", {63'd0, done}, 64'd0);
    chk("abort.hi", {32'd0, hi}, 64'd0);
    chk("abort.lo", {32'd0, lo}, 64'd0);
    $display("op abort_reset -> busy=%0b done=%0b hi=0x%h lo=0x%h", busy, done, hi, lo);
    @(negedge clk);
    rst = 1'b0;
    curHi = '0;
    curLo = '0;
    badCnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) badCnt++;
    end
    chk("abort.no_done", 64'(badCnt), 64'd0);

    // start with mthi/mtlo in IDLE: only the operation runs (MULTU 3 x 5)
    mthi = 1'b1;
    mtlo = 1'b1;
    runOp(2'd1, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 32'd0, "start_mt_multu3x5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
